// File: rtl/baccarat_datapath.sv
`default_nettype none
// ============================================================================
// Module   : baccarat_datapath
// Brief    : Card shoe, rotating rank pointer, six card registers and
//            combinational hand scoring for a baccarat table.
// Revision : 1.0 - initial release
// ============================================================================
module baccarat_datapath (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    input  logic       reshuffle,
    output logic [3:0] pcard1_out,
    output logic [3:0] pcard2_out,
    output logic [3:0] pcard3_out,
    output logic [3:0] dcard1_out,
    output logic [3:0] dcard2_out,
    output logic [3:0] dcard3_out,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [3:0] pcard3,
    output logic [5:0] cards_left,
    output logic       load_error
);

    logic [3:0] r_ptr;
    logic [2:0] r_cnt [1:13];
    logic [3:0] r_p1, r_p2, r_p3, r_d1, r_d2, r_d3;
    logic       r_err;

    logic [5:0] w_ld;
    logic       w_multi;
    logic       w_single;
    logic       w_accept;
    logic       w_empty;
    logic [5:0] w_total;
    logic [3:0] w_found_rank;
    logic [3:0] w_deal;

    // Baccarat value of a rank: face value for A..9, zero for no card and 10..K
    function automatic logic [3:0] f_value(input logic [3:0] rank);
        return (rank >= 4'd1 && rank <= 4'd9) ? rank : 4'd0;
    endfunction

    // Hand score: sum of three values (max 27) reduced mod 10 by subtraction
    function automatic logic [3:0] f_score(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] c);
        logic [4:0] s;
        s = {1'b0, f_value(a)} + {1'b0, f_value(b)} + {1'b0, f_value(c)};
        if (s >= 5'd20)
            s = s - 5'd20;
        else if (s >= 5'd10)
            s = s - 5'd10;
        return s[3:0];
    endfunction

    // Strobe vector ordered p1,p2,p3,d1,d2,d3; more than one bit set is illegal
    assign w_ld     = {load_pcard1, load_pcard2, load_pcard3,
                       load_dcard1, load_dcard2, load_dcard3};
    assign w_multi  = (w_ld & (w_ld - 6'd1)) != 6'd0;
    assign w_single = (w_ld != 6'd0) && !w_multi;
    assign w_accept = w_single && !reshuffle;
    assign w_empty  = (w_total == 6'd0);
    // An empty shoe is refilled on the dealing edge, so the pointer rank is always available
    assign w_deal   = w_empty ? r_ptr : w_found_rank;

    // Cards remaining is the sum of the per-rank counters
    always_comb begin
        w_total = 6'd0;
        for (int i = 1; i <= 13; i++)
            w_total = w_total + {3'd0, r_cnt[i]};
    end

    // First nonzero rank searching upward from the pointer, wrapping 13 -> 1
    always_comb begin
        logic [4:0] w_idx5;
        logic [3:0] w_idx;
        logic       w_hit;
        w_found_rank = r_ptr;
        w_hit        = 1'b0;
        w_idx5       = 5'd0;
        w_idx        = 4'd0;
        for (int k = 0; k < 13; k++) begin
            w_idx5 = {1'b0, r_ptr} + 5'(k);
            w_idx  = (w_idx5 > 5'd13) ? 4'(w_idx5 - 5'd13) : w_idx5[3:0];
            if (!w_hit && r_cnt[w_idx] != 3'd0) begin
                w_found_rank = w_idx;
                w_hit        = 1'b1;
            end
        end
    end

    // Free-running rank pointer and one-cycle illegal-strobe flag
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_ptr <= 4'd1;
            r_err <= 1'b0;
        end else begin
            r_ptr <= (r_ptr == 4'd13) ? 4'd1 : r_ptr + 4'd1;
            r_err <= w_multi;
        end
    end

    // Shoe counters: reshuffle wins, otherwise an accepted load removes one card
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 1; i <= 13; i++)
                r_cnt[i] <= 3'd4;
        end else if (reshuffle) begin
            for (int i = 1; i <= 13; i++)
                r_cnt[i] <= 3'd4;
        end else if (w_accept) begin
            if (w_empty) begin
                for (int i = 1; i <= 13; i++)
                    r_cnt[i] <= (4'(i) == w_deal) ? 3'd3 : 3'd4;
            end else begin
                r_cnt[w_deal] <= r_cnt[w_deal] - 3'd1;
            end
        end
    end

    // Card registers: the strobed slot captures the dealt rank; player card 1 starts a new hand
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_p1 <= 4'd0;
            r_p2 <= 4'd0;
            r_p3 <= 4'd0;
            r_d1 <= 4'd0;
            r_d2 <= 4'd0;
            r_d3 <= 4'd0;
        end else if (w_accept) begin
            if (load_pcard1) begin
                r_p1 <= w_deal;
                r_p2 <= 4'd0;
                r_p3 <= 4'd0;
                r_d1 <= 4'd0;
                r_d2 <= 4'd0;
                r_d3 <= 4'd0;
            end else if (load_pcard2) begin
                r_p2 <= w_deal;
            end else if (load_pcard3) begin
                r_p3 <= w_deal;
            end else if (load_dcard1) begin
                r_d1 <= w_deal;
            end else if (load_dcard2) begin
                r_d2 <= w_deal;
            end else begin
                r_d3 <= w_deal;
            end
        end
    end

    assign pcard1_out = r_p1;
    assign pcard2_out = r_p2;
    assign pcard3_out = r_p3;
    assign dcard1_out = r_d1;
    assign dcard2_out = r_d2;
    assign dcard3_out = r_d3;
    assign pscore     = f_score(r_p1, r_p2, r_p3);
    assign dscore     = f_score(r_d1, r_d2, r_d3);
    assign pcard3     = f_value(r_p3);
    assign cards_left = w_total;
    assign load_error = r_err;

endmodule
`default_nettype wire

// File: tb/tb_baccarat_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_baccarat_datapath
// Brief    : Scoreboard bench for baccarat_datapath with a behavioural shoe model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_baccarat_datapath;

    logic       slow_clock;
    logic       resetb;
    logic [5:0] ld;
    logic       reshuffle;
    logic [3:0] pcard1_out, pcard2_out, pcard3_out;
    logic [3:0] dcard1_out, dcard2_out, dcard3_out;
    logic [3:0] pscore, dscore, pcard3;
    logic [5:0] cards_left;
    logic       load_error;

    localparam logic [5:0] P1 = 6'b100000;
    localparam logic [5:0] P2 = 6'b010000;
    localparam logic [5:0] P3 = 6'b001000;
    localparam logic [5:0] D1 = 6'b000100;
    localparam logic [5:0] D2 = 6'b000010;
    localparam logic [5:0] D3 = 6'b000001;
    localparam logic [5:0] NONE = 6'b000000;

    baccarat_datapath u_dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .load_pcard1(ld[5]),
        .load_pcard2(ld[4]),
        .load_pcard3(ld[3]),
        .load_dcard1(ld[2]),
        .load_dcard2(ld[1]),
        .load_dcard3(ld[0]),
        .reshuffle  (reshuffle),
        .pcard1_out (pcard1_out),
        .pcard2_out (pcard2_out),
        .pcard3_out (pcard3_out),
        .dcard1_out (dcard1_out),
        .dcard2_out (dcard2_out),
        .dcard3_out (dcard3_out),
        .pscore     (pscore),
        .dscore     (dscore),
        .pcard3     (pcard3),
        .cards_left (cards_left),
        .load_error (load_error)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    typedef struct {
        int c0, c1, c2, c3, c4, c5;
        int ps, ds, p3v, cl, err;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model state
    int m_cnt [1:13];
    int m_card [6];
    int m_ptr;
    int m_err;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int val(input int r);
        return (r >= 1 && r <= 9) ? r : 0;
    endfunction

    function automatic int msum();
        int s = 0;
        for (int i = 1; i <= 13; i++) s += m_cnt[i];
        return s;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.c0 = m_card[0]; e.c1 = m_card[1]; e.c2 = m_card[2];
        e.c3 = m_card[3]; e.c4 = m_card[4]; e.c5 = m_card[5];
        e.ps  = (val(m_card[0]) + val(m_card[1]) + val(m_card[2])) % 10;
        e.ds  = (val(m_card[3]) + val(m_card[4]) + val(m_card[5])) % 10;
        e.p3v = val(m_card[2]);
        e.cl  = msum();
        e.err = m_err;
        return e;
    endfunction

    task automatic m_reset();
        for (int i = 1; i <= 13; i++) m_cnt[i] = 4;
        for (int i = 0; i < 6; i++) m_card[i] = 0;
        m_ptr = 1;
        m_err = 0;
    endtask

    task automatic m_update(input logic [5:0] s, input bit resh);
        int n;
        int r;
        int idx;
        n     = $countones(s);
        m_err = (n > 1) ? 1 : 0;
        if (resh) begin
            for (int i = 1; i <= 13; i++) m_cnt[i] = 4;
        end else if (n == 1) begin
            if (msum() == 0)
                for (int i = 1; i <= 13; i++) m_cnt[i] = 4;
            r = 0;
            for (int k = 0; k < 13; k++) begin
                int q;
                q = ((m_ptr - 1 + k) % 13) + 1;
                if (r == 0 && m_cnt[q] > 0) r = q;
            end
            m_cnt[r]--;
            idx = 0;
            for (int i = 0; i < 6; i++) if (s[5-i]) idx = i;
            m_card[idx] = r;
            if (idx == 0)
                for (int i = 1; i < 6; i++) m_card[i] = 0;
        end
        m_ptr = (m_ptr % 13) + 1;
    endtask

    task automatic check_q(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".p1"},  int'(pcard1_out), e.c0);
        chk({tag, ".p2"},  int'(pcard2_out), e.c1);
        chk({tag, ".p3"},  int'(pcard3_out), e.c2);
        chk({tag, ".d1"},  int'(dcard1_out), e.c3);
        chk({tag, ".d2"},  int'(dcard2_out), e.c4);
        chk({tag, ".d3"},  int'(dcard3_out), e.c5);
        chk({tag, ".ps"},  int'(pscore),     e.ps);
        chk({tag, ".ds"},  int'(dscore),     e.ds);
        chk({tag, ".p3v"}, int'(pcard3),     e.p3v);
        chk({tag, ".cl"},  int'(cards_left), e.cl);
        chk({tag, ".err"}, int'(load_error), e.err);
    endtask

    // Drive at a falling edge, clock once, compare at the next falling edge
    task automatic step(input logic [5:0] s, input bit resh, input string tag);
        ld        = s;
        reshuffle = resh;
        m_update(s, resh);
        exp_q.push_back(snap());
        @(posedge slow_clock);
        @(negedge slow_clock);
        ld        = NONE;
        reshuffle = 1'b0;
        check_q(tag);
    endtask

    task automatic wait_ptr(input int t);
        for (int i = 0; i < 14 && m_ptr != t; i++)
            step(NONE, 1'b0, "idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ld        = NONE;
        reshuffle = 1'b0;
        resetb    = 1'b1;
        m_reset();
        #2 resetb = 1'b0;
        #2;
        exp_q.push_back(snap());
        check_q("reset");
        chk("reset_cl", int'(cards_left), 52);
        @(negedge slow_clock);
        resetb = 1'b1;

        // First deal at pointer 1
        step(P1, 1'b0, "r24");
        chk("r24_p1", int'(pcard1_out), 1);
        chk("r24_ps", int'(pscore), 1);
        chk("r24_cl", int'(cards_left), 51);

        // Player 7, 8, K; dealer 6, 6
        wait_ptr(7);
        step(P1, 1'b0, "r25a");
        step(P2, 1'b0, "r25b");
        wait_ptr(13);
        step(P3, 1'b0, "r25c");
        chk("r25_ps", int'(pscore), 5);
        chk("r25_p3v", int'(pcard3), 0);
        chk("r25_p3", int'(pcard3_out), 13);
        wait_ptr(6);
        step(D1, 1'b0, "r25d");
        wait_ptr(6);
        step(D2, 1'b0, "r25e");
        chk("r25_ds", int'(dscore), 2);

        // Two strobes together
        step(P2 | D1, 1'b0, "r27a");
        chk("r27_err1", int'(load_error), 1);
        chk("r27_p2", int'(pcard2_out), 8);
        chk("r27_d1", int'(dcard1_out), 6);
        step(NONE, 1'b0, "r27b");
        chk("r27_err0", int'(load_error), 0);

        // Exhaust rank 5, then skip to 6
        for (int i = 0; i < 8 && m_cnt[5] > 0; i++) begin
            wait_ptr(5);
            step(D3, 1'b0, "r26x");
        end
        wait_ptr(5);
        step(D3, 1'b0, "r26a");
        chk("r26_skip", int'(dcard3_out), 6);

        // Exhaust 5..13, then wrap from 12 to rank 1
        for (int r = 5; r <= 13; r++)
            for (int j = 0; j < 5; j++)
                if (m_cnt[r] > 0) begin
                    wait_ptr(r);
                    step(D3, 1'b0, "r26y");
                end
        wait_ptr(12);
        step(D2, 1'b0, "r26b");
        chk("r26_wrap", int'(dcard2_out), 1);

        // Drain, deal from empty shoe, then reshuffle with a strobe
        for (int i = 0; i < 60 && msum() > 0; i++)
            step(P2, 1'b0, "drain");
        chk("r28_empty", int'(cards_left), 0);
        step(P2, 1'b0, "r28a");
        chk("r28_refill", int'(cards_left), 51);
        step(D1, 1'b1, "r28b");
        chk("r28_resh", int'(cards_left), 52);
        step(P1 | P2, 1'b1, "r28c");
        chk("r28_err", int'(load_error), 1);
        step(NONE, 1'b0, "r28d");

        // Asynchronous reset mid-hand
        step(P1, 1'b0, "r29h1");
        step(D1, 1'b0, "r29h2");
        #2 resetb = 1'b0;
        #1;
        m_reset();
        exp_q.push_back(snap());
        check_q("r29async");
        chk("r29_cl", int'(cards_left), 52);
        @(posedge slow_clock);
        #1 chk("r29_hold", int'(pcard1_out), 0);
        @(negedge slow_clock);
        resetb = 1'b1;
        step(P1, 1'b0, "r29a");
        chk("r29_ptr1", int'(pcard1_out), 1);
        step(P2, 1'b0, "r29b");
        chk("r29_ptr2", int'(pcard2_out), 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
